// File: rtl/mips_mc_controller_pkg.sv
// Shared MIPS definitions used by the multicycle controller.
//   opcode_t / function_t : raw instruction-register fields
//   alu_sel_t             : ALU operation select
//   mc_state_t            : multicycle FSM state (4-bit encoding, visible on state_dbg)
//   opcode / funct constants, pc_src and alu_b_sel encodings
//   decode_funct / decode_itype : map instruction fields to an ALU operation
package mips_mc_controller_pkg;

    typedef logic [5:0] opcode_t;
    typedef logic [5:0] function_t;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_sel_t;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        WB_ALU   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WR   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        HALT     = 4'd15
    } mc_state_t;

    localparam opcode_t OP_RTYPE = 6'h00;
    localparam opcode_t OP_J     = 6'h02;
    localparam opcode_t OP_BEQ   = 6'h04;
    localparam opcode_t OP_ADDI  = 6'h08;
    localparam opcode_t OP_SLTI  = 6'h0A;
    localparam opcode_t OP_ANDI  = 6'h0C;
    localparam opcode_t OP_ORI   = 6'h0D;
    localparam opcode_t OP_LW    = 6'h23;
    localparam opcode_t OP_SW    = 6'h2B;

    localparam function_t FN_ADD = 6'h20;
    localparam function_t FN_SUB = 6'h22;
    localparam function_t FN_AND = 6'h24;
    localparam function_t FN_OR  = 6'h25;
    localparam function_t FN_SLT = 6'h2A;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] ALU_B_RT  = 2'd0;
    localparam logic [1:0] ALU_B_ONE = 2'd1;
    localparam logic [1:0] ALU_B_IMM = 2'd2;

    typedef struct packed {
        logic     valid;
        alu_sel_t op;
    } alu_decode_t;

    // R-type funct field to ALU operation; valid=0 marks an undecoded funct.
    function automatic alu_decode_t decode_funct(function_t f);
        alu_decode_t d;
        d = '{valid: 1'b1, op: ALU_ADD};
        case (f)
            FN_ADD:  d.op = ALU_ADD;
            FN_SUB:  d.op = ALU_SUB;
            FN_AND:  d.op = ALU_AND;
            FN_OR:   d.op = ALU_OR;
            FN_SLT:  d.op = ALU_SLT;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

    // Immediate-arithmetic opcode to ALU operation.
    function automatic alu_sel_t decode_itype(opcode_t op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_SLTI: return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Memory wait-state counter for the multicycle controller.
//   clk, rst  : clock, synchronous active-low reset
//   clr       : restart the count (no request, or request acknowledged)
//   inc       : a request cycle without acknowledge
//   timeout   : this unacknowledged cycle is the Mem_Timeout-th in a row
module mips_mem_wait_timer #(
    parameter int unsigned Mem_Timeout = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic timeout
);

    localparam logic [7:0] Limit = 8'(Mem_Timeout - 1);

    logic [7:0] count;

    // NOTE: sequential state is written with <= only, so every register
    // samples the pre-edge value of its neighbours regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 8'd1;
        end
    end

    assign timeout = inc && (count == Limit);

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle sequencing FSM for the MIPS core.
//   clk, rst          : clock, synchronous active-low reset
//   en                : run enable, sampled in FETCH before a request is issued
//   opcode, funct     : instruction-register fields
//   zero              : ALU zero flag (beq)
//   mem_ready         : memory acknowledge (transfer = mem_req & mem_ready)
//   mem_req, mem_we, iord_sel : unified memory port control
//   ir_we, pc_we, pc_src      : instruction register / PC update
//   alu_a_sel, alu_b_sel, alu_sel : ALU operand and operation selects
//   rfd_sel, mem_to_rf_sel, rf_we : register-file write-back control
//   halted, illegal, bus_err  : sticky halt status
//   state_dbg                 : current state encoding
module mips_mc_controller
    import mips_mc_controller_pkg::*;
#(
    parameter int unsigned Mem_Timeout = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_a_sel,
    output logic [1:0] alu_b_sel,
    output alu_sel_t   alu_sel,
    output logic       rfd_sel,
    output logic       mem_to_rf_sel,
    output logic       rf_we,
    output logic       halted,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state_dbg
);

    mc_state_t   state;
    logic        fetch_pending;  // fetch request raised and not yet acknowledged
    logic        rfd_latched;    // destination select captured at decode
    logic        fetch_req;
    logic        timeout;
    alu_decode_t r_dec;

    // Once a fetch request is up it stays up even if en drops.
    assign fetch_req = (state == FETCH) && (en || fetch_pending);
    assign r_dec     = decode_funct(funct);
    assign state_dbg = state;

    mips_mem_wait_timer #(
        .Mem_Timeout(Mem_Timeout)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (!mem_req || mem_ready),
        .inc    (mem_req && !mem_ready),
        .timeout(timeout)
    );

    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord_sel      = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_src        = PC_SRC_ALU;
        alu_a_sel     = 1'b0;
        alu_b_sel     = ALU_B_RT;
        alu_sel       = ALU_AND;
        rfd_sel       = 1'b0;
        mem_to_rf_sel = 1'b0;
        rf_we         = 1'b0;
        case (state)
            FETCH: begin
                if (fetch_req) begin
                    mem_req   = 1'b1;
                    alu_b_sel = ALU_B_ONE;
                    alu_sel   = ALU_ADD;
                    // PC+1 is written back in the same cycle the word arrives.
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
            end
            DECODE: begin
                alu_b_sel = ALU_B_IMM;
                alu_sel   = ALU_ADD;
            end
            EXEC_R: begin
                alu_a_sel = 1'b1;
                alu_sel   = r_dec.op;
            end
            EXEC_I: begin
                alu_a_sel = 1'b1;
                alu_b_sel = ALU_B_IMM;
                alu_sel   = decode_itype(opcode);
            end
            WB_ALU: begin
                rf_we   = 1'b1;
                rfd_sel = rfd_latched;
            end
            MEM_ADDR: begin
                alu_a_sel = 1'b1;
                alu_b_sel = ALU_B_IMM;
                alu_sel   = ALU_ADD;
            end
            MEM_RD: begin
                mem_req  = 1'b1;
                iord_sel = 1'b1;
            end
            MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                iord_sel = 1'b1;
            end
            WB_MEM: begin
                rf_we         = 1'b1;
                mem_to_rf_sel = 1'b1;
            end
            BRANCH: begin
                alu_a_sel = 1'b1;
                alu_sel   = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_we     = zero;
            end
            JUMP: begin
                pc_we  = 1'b1;
                pc_src = PC_SRC_JUMP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= FETCH;
            fetch_pending <= 1'b0;
            rfd_latched   <= 1'b0;
            halted        <= 1'b0;
            illegal       <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (fetch_req) begin
                        if (mem_ready) begin
                            state         <= DECODE;
                            fetch_pending <= 1'b0;
                        end else if (timeout) begin
                            state         <= HALT;
                            fetch_pending <= 1'b0;
                            halted        <= 1'b1;
                            bus_err       <= 1'b1;
                        end else begin
                            fetch_pending <= 1'b1;
                        end
                    end
                end
                DECODE: begin
                    case (opcode)
                        OP_RTYPE: begin
                            if (r_dec.valid) begin
                                state       <= EXEC_R;
                                rfd_latched <= 1'b1;
                            end else begin
                                state   <= HALT;
                                halted  <= 1'b1;
                                illegal <= 1'b1;
                            end
                        end
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                            state       <= EXEC_I;
                            rfd_latched <= 1'b0;
                        end
                        OP_LW, OP_SW: state <= MEM_ADDR;
                        OP_BEQ:       state <= BRANCH;
                        OP_J:         state <= JUMP;
                        default: begin
                            state   <= HALT;
                            halted  <= 1'b1;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                EXEC_R, EXEC_I: state <= WB_ALU;
                MEM_ADDR:       state <= (opcode == OP_SW) ? MEM_WR : MEM_RD;
                MEM_RD, MEM_WR: begin
                    if (mem_ready) begin
                        state <= (state == MEM_RD) ? WB_MEM : FETCH;
                    end else if (timeout) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        bus_err <= 1'b1;
                    end
                end
                WB_ALU, WB_MEM, BRANCH, JUMP: state <= FETCH;
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller (Mem_Timeout = 4).
// The stimulus process drives one cycle at a time and queues the hand-written
// expected outputs for that cycle; the monitor pops and compares on the
// falling edge.
module tb_mips_mc_controller;
    import mips_mc_controller_pkg::*;

    logic       clk = 1'b0;
    logic       rst, en, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       mem_req, mem_we, iord_sel, ir_we, pc_we;
    logic [1:0] pc_src, alu_b_sel;
    logic       alu_a_sel, rfd_sel, mem_to_rf_sel, rf_we;
    alu_sel_t   alu_sel;
    logic       halted, illegal, bus_err;
    logic [3:0] state_dbg;

    always #5 clk = ~clk;

    mips_mc_controller #(.Mem_Timeout(4)) dut (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .iord_sel(iord_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_sel(alu_sel),
        .rfd_sel(rfd_sel), .mem_to_rf_sel(mem_to_rf_sel), .rf_we(rf_we),
        .halted(halted), .illegal(illegal), .bus_err(bus_err),
        .state_dbg(state_dbg)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_we, iord, ir_we, pc_we;
        logic [1:0] pc_src;
        logic       a_sel;
        logic [1:0] b_sel;
        logic [2:0] alu;
        logic       rfd, m2r, rf_we, halted, illegal, bus_err;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  o;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Hand-written expected output vectors per state.
    function automatic obs_t o_st(logic [3:0] st);
        obs_t o = '0;
        o.st = st;
        return o;
    endfunction
    function automatic obs_t o_fetch(logic ack);
        obs_t o = o_st(4'd0);
        o.mem_req = 1'b1; o.b_sel = 2'd1; o.alu = ALU_ADD;
        o.ir_we = ack; o.pc_we = ack;
        return o;
    endfunction
    function automatic obs_t o_decode();
        obs_t o = o_st(4'd1);
        o.b_sel = 2'd2; o.alu = ALU_ADD;
        return o;
    endfunction
    function automatic obs_t o_exec_r(alu_sel_t a);
        obs_t o = o_st(4'd2);
        o.a_sel = 1'b1; o.alu = a;
        return o;
    endfunction
    function automatic obs_t o_exec_i(alu_sel_t a);
        obs_t o = o_st(4'd3);
        o.a_sel = 1'b1; o.b_sel = 2'd2; o.alu = a;
        return o;
    endfunction
    function automatic obs_t o_wb_alu(logic rfd);
        obs_t o = o_st(4'd4);
        o.rf_we = 1'b1; o.rfd = rfd;
        return o;
    endfunction
    function automatic obs_t o_mem_addr();
        obs_t o = o_st(4'd5);
        o.a_sel = 1'b1; o.b_sel = 2'd2; o.alu = ALU_ADD;
        return o;
    endfunction
    function automatic obs_t o_mem_rd();
        obs_t o = o_st(4'd6);
        o.mem_req = 1'b1; o.iord = 1'b1;
        return o;
    endfunction
    function automatic obs_t o_mem_wr();
        obs_t o = o_st(4'd7);
        o.mem_req = 1'b1; o.mem_we = 1'b1; o.iord = 1'b1;
        return o;
    endfunction
    function automatic obs_t o_wb_mem();
        obs_t o = o_st(4'd8);
        o.rf_we = 1'b1; o.m2r = 1'b1;
        return o;
    endfunction
    function automatic obs_t o_branch(logic z);
        obs_t o = o_st(4'd9);
        o.a_sel = 1'b1; o.alu = ALU_SUB; o.pc_src = 2'd1; o.pc_we = z;
        return o;
    endfunction
    function automatic obs_t o_jump();
        obs_t o = o_st(4'd10);
        o.pc_we = 1'b1; o.pc_src = 2'd2;
        return o;
    endfunction
    function automatic obs_t o_halt(logic ill, logic be);
        obs_t o = o_st(4'd15);
        o.halted = 1'b1; o.illegal = ill; o.bus_err = be;
        return o;
    endfunction

    // One clock cycle: apply inputs, queue what the DUT must show this cycle.
    task automatic step(input string tag, input logic r, input logic e,
                        input logic rdy, input obs_t o);
        rst = r; en = e; mem_ready = rdy;
        sb.push_back('{tag, o});
        @(posedge clk);
        #1;
    endtask

    // Monitor: one comparison per queued expectation, away from the rising edge.
    always @(negedge clk) begin
        exp_t e;
        obs_t a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a.st = state_dbg; a.mem_req = mem_req; a.mem_we = mem_we;
            a.iord = iord_sel; a.ir_we = ir_we; a.pc_we = pc_we;
            a.pc_src = pc_src; a.a_sel = alu_a_sel; a.b_sel = alu_b_sel;
            a.alu = alu_sel; a.rfd = rfd_sel; a.m2r = mem_to_rf_sel;
            a.rf_we = rf_we; a.halted = halted; a.illegal = illegal;
            a.bus_err = bus_err;
            n_cmp++;
            if (a !== e.o) begin
                n_err++;
                $display("FAIL %s: got %h required %h (state got %0d required %0d)",
                         e.tag, a, e.o, a.st, e.o.st);
            end
        end
    end

    initial begin
        rst = 1'b0; en = 1'b0; mem_ready = 1'b0;
        opcode = '0; funct = '0; zero = 1'b0;
        @(posedge clk);
        #1;

        // Reset state and ignored acknowledge while idle.
        step("reset idle", 1'b0, 1'b0, 1'b0, o_st(4'd0));
        step("idle rdy",   1'b1, 1'b0, 1'b1, o_st(4'd0));

        // R-type add, zero wait: 4 cycles.
        opcode = OP_RTYPE; funct = FN_ADD;
        step("add fetch",  1'b1, 1'b1, 1'b1, o_fetch(1'b1));
        step("add decode", 1'b1, 1'b1, 1'b1, o_decode());
        step("add exec",   1'b1, 1'b1, 1'b1, o_exec_r(ALU_ADD));
        step("add wb",     1'b1, 1'b1, 1'b1, o_wb_alu(1'b1));

        // R-type sub.
        funct = FN_SUB;
        step("sub fetch",  1'b1, 1'b1, 1'b1, o_fetch(1'b1));
        step("sub decode", 1'b1, 1'b1, 1'b1, o_decode());
        step("sub exec",   1'b1, 1'b1, 1'b1, o_exec_r(ALU_SUB));
        step("sub wb",     1'b1, 1'b1, 1'b1, o_wb_alu(1'b1));

        // I-type slti and ori: rt destination.
        opcode = OP_SLTI;
        step("slti fetch",  1'b1, 1'b1, 1'b1, o_fetch(1'b1));
        step("slti decode", 1'b1, 1'b1, 1'b1, o_decode());
        step("slti exec",   1'b1, 1'b1, 1'b1, o_exec_i(ALU_SLT));
        step("slti wb",     1'b1, 1'b1, 1'b1, o_wb_alu(1'b0));
        opcode = OP_ORI;
        step("ori fetch",  1'b1, 1'b1, 1'b1, o_fetch(1'b1));
        step("ori decode", 1'b1, 1'b1, 1'b1, o_decode());
        step("ori exec",   1'b1, 1'b1, 1'b1, o_exec_i(ALU_OR));
        step("ori wb",     1'b1, 1'b1, 1'b1, o_wb_alu(1'b0));

        // lw with 3 data wait cycles (en dropped meanwhile): 8 cycles.
        opcode = OP_LW;
        step("lw fetch",   1'b1, 1'b1, 1'b1, o_fetch(1'b1));
        step("lw decode",  1'b1, 1'b1, 1'b1, o_decode());
        step("lw addr",    1'b1, 1'b1, 1'b1, o_mem_addr());
        step("lw wait1",   1'b1, 1'b0, 1'b0, o_mem_rd());
        step("lw wait2",   1'b1, 1'b0, 1'b0, o_mem_rd());
        step("lw wait3",   1'b1, 1'b0, 1'b0, o_mem_rd());
        step("lw ack",     1'b1, 1'b0, 1'b1, o_mem_rd());
        step("lw wb",      1'b1, 1'b1, 1'b1, o_wb_mem());

        // sw, zero wait: 4 cycles.
        opcode = OP_SW;
        step("sw fetch",  1'b1, 1'b1, 1'b1, o_fetch(1'b1));
        step("sw decode", 1'b1, 1'b1, 1'b1, o_decode());
        step("sw addr",   1'b1, 1'b1, 1'b1, o_mem_addr());
        step("sw write",  1'b1, 1'b1, 1'b1, o_mem_wr());

        // beq taken, then not taken.
        opcode = OP_BEQ; zero = 1'b1;
        step("beq1 fetch",  1'b1, 1'b1, 1'b1, o_fetch(1'b1));
        step("beq1 decode", 1'b1, 1'b1, 1'b1, o_decode());
        step("beq1 taken",  1'b1, 1'b1, 1'b1, o_branch(1'b1));
        zero = 1'b0;
        step("beq0 fetch",  1'b1, 1'b1, 1'b1, o_fetch(1'b1));
        step("beq0 decode", 1'b1, 1'b1, 1'b1, o_decode());
        step("beq0 not",    1'b1, 1'b1, 1'b1, o_branch(1'b0));

        // j, with the fetch request held across an en drop.
        opcode = OP_J;
        step("j fetch wait",  1'b1, 1'b1, 1'b0, o_fetch(1'b0));
        step("j fetch en0",   1'b1, 1'b0, 1'b0, o_fetch(1'b0));
        step("j fetch ack",   1'b1, 1'b0, 1'b1, o_fetch(1'b1));
        step("j decode",      1'b1, 1'b0, 1'b1, o_decode());
        step("j jump",        1'b1, 1'b0, 1'b1, o_jump());

        // Reset in the middle of a data read.
        opcode = OP_LW;
        step("rlw fetch",  1'b1, 1'b1, 1'b1, o_fetch(1'b1));
        step("rlw decode", 1'b1, 1'b1, 1'b1, o_decode());
        step("rlw addr",   1'b1, 1'b1, 1'b1, o_mem_addr());
        step("rlw wait",   1'b1, 1'b1, 1'b0, o_mem_rd());
        step("rlw rst",    1'b0, 1'b1, 1'b0, o_mem_rd());
        opcode = OP_J;
        step("post-rst fetch", 1'b1, 1'b1, 1'b0, o_fetch(1'b0));
        step("post-rst ack",   1'b1, 1'b1, 1'b1, o_fetch(1'b1));
        step("post-rst dec",   1'b1, 1'b1, 1'b1, o_decode());
        step("post-rst jump",  1'b1, 1'b1, 1'b1, o_jump());

        // Undecoded funct halts.
        opcode = OP_RTYPE; funct = 6'h3F;
        step("badfn fetch",  1'b1, 1'b1, 1'b1, o_fetch(1'b1));
        step("badfn decode", 1'b1, 1'b1, 1'b1, o_decode());
        step("badfn halt",   1'b1, 1'b1, 1'b1, o_halt(1'b1, 1'b0));
        step("badfn rst",    1'b0, 1'b0, 1'b0, o_halt(1'b1, 1'b0));

        // Illegal opcode halts and absorbs en / mem_ready activity.
        opcode = 6'h3F;
        step("badop fetch",  1'b1, 1'b1, 1'b1, o_fetch(1'b1));
        step("badop decode", 1'b1, 1'b1, 1'b1, o_decode());
        step("badop halt1",  1'b1, 1'b1, 1'b1, o_halt(1'b1, 1'b0));
        step("badop halt2",  1'b1, 1'b0, 1'b0, o_halt(1'b1, 1'b0));
        step("badop halt3",  1'b1, 1'b1, 1'b1, o_halt(1'b1, 1'b0));
        step("badop rst",    1'b0, 1'b0, 1'b1, o_halt(1'b1, 1'b0));
        step("badop idle",   1'b1, 1'b0, 1'b0, o_st(4'd0));

        // Fetch timeout: 4th unacknowledged request cycle halts with bus_err.
        step("to req1",  1'b1, 1'b1, 1'b0, o_fetch(1'b0));
        step("to req2",  1'b1, 1'b1, 1'b0, o_fetch(1'b0));
        step("to req3",  1'b1, 1'b1, 1'b0, o_fetch(1'b0));
        step("to req4",  1'b1, 1'b1, 1'b0, o_fetch(1'b0));
        step("to halt1", 1'b1, 1'b1, 1'b1, o_halt(1'b0, 1'b1));
        step("to halt2", 1'b1, 1'b1, 1'b1, o_halt(1'b0, 1'b1));
        step("to rst",   1'b0, 1'b0, 1'b0, o_halt(1'b0, 1'b1));
        step("to idle",  1'b1, 1'b0, 1'b0, o_st(4'd0));

        // Bounded drain of anything the monitor has not yet consumed.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
